// File: rtl/score_pkg.sv
// Shared constants and slot typedef for the score display.
package score_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;
    localparam logic [3:0] AN_UNITS  = 4'b1110;
    localparam logic [3:0] AN_TENS   = 4'b1101;

    typedef enum logic [1:0] {
        SLOT_UNITS,
        SLOT_TENS,
        SLOT_PAD2,
        SLOT_PAD3
    } slot_t;

endpackage

// File: rtl/score_display_seg7_decode.sv
// BCD to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module seg7_decode
    import score_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        unique case (val)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/score_display.sv
// Multiplexed 4-digit seven-segment driver for the two score digits.
// Optional max-score blinking is enabled with `define SCORE_BLINK_EN.
module score_display
    import score_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int DIV_WIDTH   = 17,
    parameter int MAX_SCORE   = 8,
    parameter int BLINK_DIV   = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] val_1,
    input  logic [3:0] val_0,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    logic [DIV_WIDTH-1:0] cnt;
    logic                 tick;
    slot_t                idx;
    slot_t                nxt_idx;
    logic                 frame_end;
    logic [3:0]           units_q;
    logic [3:0]           tens_q;
    logic [3:0]           nxt_units;
    logic [3:0]           nxt_tens;
    logic [3:0]           nxt_digit;
    logic [6:0]           dec_seg;
    logic [6:0]           nxt_seg;
    logic [3:0]           slot_an;
    logic                 blink_hide;

    assign tick = (cnt == DIV_WIDTH'(REFRESH_DIV - 1));

    // Pattern for the slot being entered is prepared from next-state values
    always_comb begin
        frame_end = (idx == SLOT_PAD3);
        nxt_idx   = slot_t'(idx + 2'd1);
        nxt_units = frame_end ? val_0 : units_q;
        nxt_tens  = frame_end ? val_1 : tens_q;
        nxt_digit = (nxt_idx == SLOT_TENS) ? nxt_tens : nxt_units;
    end

    seg7_decode u_dec (
        .val (nxt_digit),
        .seg (dec_seg)
    );

    always_comb begin
        nxt_seg = SEG_BLANK;
        unique case (nxt_idx)
            SLOT_UNITS: nxt_seg = dec_seg;
            SLOT_TENS:  nxt_seg = dec_seg;
            default:    nxt_seg = SEG_BLANK;
        endcase
    end

    always_comb begin
        slot_an = AN_OFF;
        unique case (idx)
            SLOT_UNITS: slot_an = AN_UNITS;
            SLOT_TENS:  slot_an = (tens_q == 4'd0) ? AN_OFF : AN_TENS;
            default:    slot_an = AN_OFF;
        endcase
        if (blink_hide) slot_an = AN_OFF;
    end

`ifdef SCORE_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BW-1:0] blink_cnt;
    logic          phase;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign blink_hide = phase && (tens_q == 4'(MAX_SCORE));
`else
    // Blink parameters only matter when the feature is built in
    assign blink_hide = (BLINK_DIV < 0) && (MAX_SCORE < 0);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            idx     <= SLOT_UNITS;
            units_q <= 4'd0;
            tens_q  <= 4'd0;
            seg     <= SEG_BLANK;
            an      <= AN_OFF;
            dp      <= 1'b1;
        end else begin
            dp <= 1'b1;
            if (tick) begin
                cnt     <= '0;
                idx     <= nxt_idx;
                units_q <= nxt_units;
                tens_q  <= nxt_tens;
                seg     <= nxt_seg;
                // Guard cycle: anodes off while segments settle
                an      <= AN_OFF;
            end else begin
                cnt <= cnt + 1'b1;
                an  <= slot_an;
            end
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display with a scan-arithmetic model.
module tb_score_display;

    localparam int D  = 4;
    localparam int BD = 2;

    logic       clock;
    logic       reset;
    logic [3:0] val_1;
    logic [3:0] val_0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int checks;
    int failures;

    int         n;
    logic [3:0] snap_u;
    logic [3:0] snap_t;
    logic [6:0] pat [16];

    score_display #(
        .REFRESH_DIV (D),
        .DIV_WIDTH   (3),
        .MAX_SCORE   (8),
        .BLINK_DIV   (BD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .val_1 (val_1),
        .val_0 (val_0),
        .seg   (seg),
        .dp    (dp),
        .an    (an)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h n=%0d",
                     name, act, exp, n);
        end
    endtask

    // Model: n edges since reset release; every D edges one slot passes
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            n      = 0;
            snap_u = 4'd0;
            snap_t = 4'd0;
        end else begin
            n = n + 1;
            if (n % D == 0 && (n / D) % 4 == 0) begin
                snap_u = val_0;
                snap_t = val_1;
            end
        end
    end

    function automatic logic [3:0] exp_an();
        int m;
        int s;
        logic [3:0] r;
        m = n / D;
        s = m % 4;
        if (n == 0) return 4'b1111;
        if (m > 0 && n % D == 0) return 4'b1111;
        case (s)
            0:       r = 4'b1110;
            1:       r = (snap_t == 0) ? 4'b1111 : 4'b1101;
            default: r = 4'b1111;
        endcase
`ifdef SCORE_BLINK_EN
        if (snap_t == 4'd8 && ((m / BD) % 2) == 1) r = 4'b1111;
`endif
        return r;
    endfunction

    function automatic logic [6:0] exp_seg();
        int m;
        m = n / D;
        if (m == 0) return 7'b1111111;
        case (m % 4)
            0:       return pat[snap_u];
            1:       return pat[snap_t];
            default: return 7'b1111111;
        endcase
    endfunction

    always @(negedge clock) begin
        if (reset) begin
            chk("an", {28'd0, an}, {28'd0, exp_an()});
            chk("seg", {25'd0, seg}, {25'd0, exp_seg()});
            chk("dp", {31'd0, dp}, 32'd1);
            chk("an_onehot", {31'd0, ($countones(~an) <= 1)}, 32'd1);
        end
    end

    task automatic wait_n(input int target);
        int budget;
        budget = 1000;
        while (n < target && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (n != target) begin
            failures++;
            checks++;
            $display("FAIL wait_n actual=%0d expected=%0d", n, target);
        end
    endtask

    initial begin
        pat[0]  = 7'b1000000; pat[1]  = 7'b1111001;
        pat[2]  = 7'b0100100; pat[3]  = 7'b0110000;
        pat[4]  = 7'b0011001; pat[5]  = 7'b0010010;
        pat[6]  = 7'b0000010; pat[7]  = 7'b1111000;
        pat[8]  = 7'b0000000; pat[9]  = 7'b0010000;
        for (int i = 10; i < 16; i++) pat[i] = 7'b0111111;
        checks   = 0;
        failures = 0;
        val_1    = 4'd3;
        val_0    = 4'd7;
        reset    = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_an", {28'd0, an}, 32'hf);
        chk("rst_seg", {25'd0, seg}, 32'h7f);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        reset = 1'b1;

        wait_n(17);
        chk("l_units_an", {28'd0, an}, 32'he);
        chk("l_units_seg", {25'd0, seg}, {25'd0, 7'b1111000});
        wait_n(20);
        chk("l_guard_an", {28'd0, an}, 32'hf);
        chk("l_guard_seg", {25'd0, seg}, {25'd0, 7'b0110000});
        wait_n(21);
        chk("l_tens_an", {28'd0, an}, 32'hd);
        chk("l_tens_seg", {25'd0, seg}, {25'd0, 7'b0110000});
        val_1 = 4'd0;
        val_0 = 4'd5;

        wait_n(33);
        chk("l_five_an", {28'd0, an}, 32'he);
        chk("l_five_seg", {25'd0, seg}, {25'd0, 7'b0010010});
        wait_n(38);
        chk("l_lzb_an", {28'd0, an}, 32'hf);
        val_0 = 4'd2;

        wait_n(49);
        chk("l_two_seg", {25'd0, seg}, {25'd0, 7'b0100100});
        wait_n(53);
        val_0 = 4'd9;
        wait_n(57);
        chk("l_pad_an", {28'd0, an}, 32'hf);
        chk("l_pad_seg", {25'd0, seg}, 32'h7f);
        wait_n(65);
        chk("l_nine_an", {28'd0, an}, 32'he);
        chk("l_nine_seg", {25'd0, seg}, {25'd0, 7'b0010000});
        val_0 = 4'd12;

        wait_n(81);
        chk("l_dash_seg", {25'd0, seg}, {25'd0, 7'b0111111});
        wait_n(82);
        chk("l_pre_rst_an", {28'd0, an}, 32'he);
        #2 reset = 1'b0;
        #1;
        chk("l_async_an", {28'd0, an}, 32'hf);
        chk("l_async_seg", {25'd0, seg}, 32'h7f);
        val_1 = 4'd8;
        val_0 = 4'd1;
        @(negedge clock);
        reset = 1'b1;

        wait_n(21);
        chk("l_eight_an", {28'd0, an}, 32'hd);
        chk("l_eight_seg", {25'd0, seg}, 32'h00);
        wait_n(70);
        val_1 = 4'd7;
        wait_n(130);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
